scan_chain_controller: RTL

//  Drives the scan_enable/scan_in side of a scan_shift_register chain and captures its scan_out.
//  Per command:
//  - optionally pulses one functional step (func_step) so the DES core captures state;
//  - serially shifts a CHAIN_LEN-bit vector into the chain;
//  - returns the CHAIN_LEN bits that fell out.

---
 rtl/scan_chain_controller_pkg.sv | 18 +
 rtl/scan_chain_controller_if.sv | 24 ++
 rtl/scan_shift_counter.sv | 27 ++
 rtl/scan_chain_controller.sv | 80 ++++++++
 4 files changed

// File: rtl/scan_chain_controller_pkg.sv
// rtl/scan_chain_controller_pkg.sv - op codes, state encodings and helpers for the scan chain controller
package scan_chain_controller_pkg;

   localparam logic [1:0] OP_SHIFT      = 2'b00;
   localparam logic [1:0] OP_STEP_SHIFT = 2'b01;
   localparam logic [1:0] OP_STEP       = 2'b10;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_STEP  = 2'd1;
   localparam logic [1:0] ST_SHIFT = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

   // Reserved op 11 behaves as a plain SHIFT, so only 01 and 10 pulse the core.
   function automatic logic op_has_step(input logic [1:0] op);
      return (op == OP_STEP_SHIFT) || (op == OP_STEP);
   endfunction

endpackage

// File: rtl/scan_chain_controller_if.sv
// rtl/scan_chain_controller_if.sv - command/response handshake bundle between SPI decoder and scan controller
interface scan_chain_controller_if #(
   parameter int CHAIN_LEN = 64
);

   logic                 cmd_valid;
   logic                 cmd_ready;
   logic [1:0]           cmd_op;
   logic [CHAIN_LEN-1:0] cmd_data;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [CHAIN_LEN-1:0] rsp_data;

   modport master (
      output cmd_valid, cmd_op, cmd_data, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_data, rsp_ready,
      output cmd_ready, rsp_valid, rsp_data
   );

endinterface

// File: rtl/scan_shift_counter.sv
// rtl/scan_shift_counter.sv - loadable down-counter tracking the remaining shift cycles
module scan_shift_counter #(
   parameter int CNT_W = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             dec,
   input  logic [CNT_W-1:0] load_val,
   output logic             last
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign last = (count == CNT_W'(1));

endmodule

// File: rtl/scan_chain_controller.sv
// rtl/scan_chain_controller.sv - sequences functional step and serial shift of a scan chain per command
module scan_chain_controller
   import scan_chain_controller_pkg::*;
#(
   parameter int CHAIN_LEN = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   scan_chain_controller_if.slave  bus,
   output logic                    scan_enable,
   output logic                    scan_in,
   input  logic                    scan_out,
   output logic                    func_step,
   output logic                    busy
);

   localparam int CNT_W = $clog2(CHAIN_LEN + 1);

   logic [1:0]           state;
   logic [1:0]           op;
   logic [CHAIN_LEN-1:0] load_reg;
   logic [CHAIN_LEN-1:0] capture_reg;
   logic                 cnt_last;
   logic                 accept;

   assign accept = (state == ST_IDLE) && bus.cmd_valid;

   scan_shift_counter #(.CNT_W(CNT_W)) u_counter (
      .clk      (clk),
      .rst      (rst),
      .load     (accept),
      .dec      (state == ST_SHIFT),
      .load_val (CNT_W'(CHAIN_LEN)),
      .last     (cnt_last)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         op          <= OP_SHIFT;
         load_reg    <= '0;
         capture_reg <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.cmd_valid) begin
                  op       <= bus.cmd_op;
                  load_reg <= bus.cmd_data;
                  state    <= op_has_step(bus.cmd_op) ? ST_STEP : ST_SHIFT;
               end
            end
            ST_STEP: begin
               state <= (op == OP_STEP) ? ST_RESP : ST_SHIFT;
            end
            ST_SHIFT: begin
               // First bit out of the chain ends up in the capture MSB.
               load_reg    <= load_reg << 1;
               capture_reg <= {capture_reg[CHAIN_LEN-2:0], scan_out};
               if (cnt_last) begin
                  state <= ST_RESP;
               end
            end
            default: begin
               if (bus.rsp_ready) begin
                  state <= ST_IDLE;
               end
            end
         endcase
      end
   end

   assign bus.cmd_ready = (state == ST_IDLE);
   assign bus.rsp_valid = (state == ST_RESP);
   assign bus.rsp_data  = capture_reg;
   assign scan_enable   = (state == ST_SHIFT);
   assign func_step     = (state == ST_STEP);
   assign busy          = (state != ST_IDLE);
   assign scan_in       = load_reg[CHAIN_LEN-1];

endmodule
